// File: rtl/input_conditioner_if.sv
// Bundles the per-channel input and conditioned output vectors of the input conditioner.
// The master side drives the raw inputs and clears. The slave side is the conditioner itself.
interface input_conditioner_if #(
   parameter int WIDTH = 21
);
   logic [WIDTH-1:0] async_in;
   logic [WIDTH-1:0] toggle_clr;
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] clean_out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] toggle_out;

   modport master (
      output async_in, toggle_clr,
      input  sync_out, clean_out, rise, fall, toggle_out
   );

   modport slave (
      input  async_in, toggle_clr,
      output sync_out, clean_out, rise, fall, toggle_out
   );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel pushbutton front end. Each channel is processed independently in four stages:
// a synchronizer, a debouncer, rise/fall edge pulses, and a toggle latch.
module input_conditioner #(
   parameter int WIDTH           = 21,
   parameter int STAGES          = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input logic                 clk,
   input logic                 n_rst,
   input_conditioner_if.slave  bus
);
   localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_vec;
   logic [WIDTH-1:0] clean_vec;
   logic [WIDTH-1:0] rise_vec;
   logic [WIDTH-1:0] fall_vec;
   logic [WIDTH-1:0] toggle_vec;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_ch
         logic [STAGES-1:0] sync_q;
         logic [CW-1:0]     cnt_q, cnt_d;
         logic              clean_q, clean_d;
         logic              rise_q, fall_q;
         logic              toggle_q, toggle_d;
         logic              sync_s;

         assign sync_s = sync_q[STAGES-1];

         // Plain shift chain: nothing may sit between the metastability flops.
         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               sync_q <= '0;
            end else begin
               sync_q <= {sync_q[STAGES-2:0], bus.async_in[gi]};
            end
         end

         always_comb begin
            cnt_d    = cnt_q;
            clean_d  = clean_q;
            toggle_d = toggle_q;
            if (sync_s == clean_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               clean_d = sync_s;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            // A clear has priority over a rise arriving on the same edge.
            if (bus.toggle_clr[gi]) begin
               toggle_d = 1'b0;
            end else if (clean_d && !clean_q) begin
               toggle_d = ~toggle_q;
            end
         end

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               cnt_q    <= '0;
               clean_q  <= 1'b0;
               rise_q   <= 1'b0;
               fall_q   <= 1'b0;
               toggle_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               clean_q  <= clean_d;
               rise_q   <= clean_d & ~clean_q;
               fall_q   <= ~clean_d & clean_q;
               toggle_q <= toggle_d;
            end
         end

         assign sync_vec[gi]   = sync_s;
         assign clean_vec[gi]  = clean_q;
         assign rise_vec[gi]   = rise_q;
         assign fall_vec[gi]   = fall_q;
         assign toggle_vec[gi] = toggle_q;
      end
   endgenerate

   assign bus.sync_out   = sync_vec;
   assign bus.clean_out  = clean_vec;
   assign bus.rise       = rise_vec;
   assign bus.fall       = fall_vec;
   assign bus.toggle_out = toggle_vec;
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with WIDTH=4, STAGES=2 and DEBOUNCE_CYCLES=4.
// Edge numbers count rising edges after the inputs are set, starting at 1.
module tb_input_conditioner;
   logic clk;
   logic n_rst;
   int   total;
   int   bad;

   input_conditioner_if #(.WIDTH(4)) bus ();

   input_conditioner #(
      .WIDTH          (4),
      .STAGES         (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk  (clk),
      .n_rst(n_rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset is released between edges, so the next rising edge is edge 1.
   task automatic apply_reset();
      n_rst          = 1'b0;
      bus.async_in   = '0;
      bus.toggle_clr = '0;
      tick();
      tick();
      n_rst = 1'b1;
   endtask

   task automatic test_reset();
      n_rst          = 1'b1;
      bus.async_in   = '0;
      bus.toggle_clr = '0;
      #2 n_rst = 1'b0;
      #1;
      total++;
      if ({bus.sync_out, bus.clean_out, bus.rise, bus.fall, bus.toggle_out} !== 20'h0) begin
         bad++;
         $display("FAIL reset_state got=%h exp=0",
                  {bus.sync_out, bus.clean_out, bus.rise, bus.fall, bus.toggle_out});
      end
   endtask

   task automatic test_latency();
      apply_reset();
      bus.async_in[0] = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         tick();
         total++;
         if (bus.sync_out[0] !== (e >= 2)) begin
            bad++;
            $display("FAIL latency_sync e=%0d got=%b exp=%b", e, bus.sync_out[0], e >= 2);
         end
         total++;
         if (bus.clean_out[0] !== (e >= 6)) begin
            bad++;
            $display("FAIL latency_clean e=%0d got=%b exp=%b", e, bus.clean_out[0], e >= 6);
         end
         total++;
         if (bus.rise[0] !== (e == 6) || bus.fall[0] !== 1'b0) begin
            bad++;
            $display("FAIL latency_edge e=%0d rise=%b fall=%b exp_rise=%b",
                     e, bus.rise[0], bus.fall[0], e == 6);
         end
         total++;
         if (bus.toggle_out[0] !== (e >= 6)) begin
            bad++;
            $display("FAIL latency_toggle e=%0d got=%b exp=%b", e, bus.toggle_out[0], e >= 6);
         end
      end
   endtask

   // A 3-cycle pulse is one short of acceptance; a 4-cycle pulse just passes.
   task automatic test_glitch();
      apply_reset();
      bus.async_in[1] = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 3) bus.async_in[1] = 1'b0;
         total++;
         if (bus.sync_out[1] !== (e >= 2 && e <= 4)) begin
            bad++;
            $display("FAIL glitch3_sync e=%0d got=%b exp=%b", e, bus.sync_out[1], e >= 2 && e <= 4);
         end
         total++;
         if ({bus.clean_out[1], bus.rise[1], bus.fall[1], bus.toggle_out[1]} !== 4'b0000) begin
            bad++;
            $display("FAIL glitch3_out e=%0d got=%b exp=0000", e,
                     {bus.clean_out[1], bus.rise[1], bus.fall[1], bus.toggle_out[1]});
         end
      end
      apply_reset();
      bus.async_in[1] = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 4) bus.async_in[1] = 1'b0;
         total++;
         if ({bus.clean_out[1], bus.rise[1], bus.fall[1], bus.toggle_out[1]} !==
             {(e >= 6 && e <= 9), (e == 6), (e == 10), (e >= 6)}) begin
            bad++;
            $display("FAIL glitch4 e=%0d got=%b exp=%b", e,
                     {bus.clean_out[1], bus.rise[1], bus.fall[1], bus.toggle_out[1]},
                     {(e >= 6 && e <= 9), (e == 6), (e == 10), (e >= 6)});
         end
      end
   endtask

   // Each press: high sampled at edges 1..8, low at 9..16; rise after 6, fall after 14.
   task automatic test_toggle();
      logic [2:0] tog_after;
      logic       tog_before;
      tog_after  = 3'b101;
      tog_before = 1'b0;
      apply_reset();
      for (int p = 0; p < 3; p++) begin
         bus.async_in[2] = 1'b1;
         for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 8) bus.async_in[2] = 1'b0;
            total++;
            if ({bus.rise[2], bus.fall[2], bus.toggle_out[2]} !==
                {(e == 6), (e == 14), (e >= 6) ? tog_after[p] : tog_before}) begin
               bad++;
               $display("FAIL toggle_press%0d e=%0d got=%b exp=%b", p, e,
                        {bus.rise[2], bus.fall[2], bus.toggle_out[2]},
                        {(e == 6), (e == 14), (e >= 6) ? tog_after[p] : tog_before});
            end
         end
         tog_before = tog_after[p];
      end
   endtask

   task automatic test_clear_priority();
      apply_reset();
      bus.async_in[3] = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick();
         if (e == 8) bus.async_in[3] = 1'b0;
      end
      total++;
      if (bus.toggle_out[3] !== 1'b1) begin
         bad++;
         $display("FAIL clr_setup got=%b exp=1", bus.toggle_out[3]);
      end
      bus.async_in[3] = 1'b1;
      for (int e = 1; e <= 5; e++) tick();
      bus.toggle_clr[3] = 1'b1;
      tick();
      bus.toggle_clr[3] = 1'b0;
      total++;
      if ({bus.clean_out[3], bus.rise[3], bus.toggle_out[3]} !== 3'b110) begin
         bad++;
         $display("FAIL clr_priority got=%b exp=110",
                  {bus.clean_out[3], bus.rise[3], bus.toggle_out[3]});
      end
      tick();
      total++;
      if ({bus.rise[3], bus.toggle_out[3]} !== 2'b00) begin
         bad++;
         $display("FAIL clr_hold got=%b exp=00", {bus.rise[3], bus.toggle_out[3]});
      end
   endtask

   // Channel 1 starts two edges ahead so its rise coincides with channel 0 at cnt=2.
   task automatic test_async_reset();
      apply_reset();
      bus.async_in[1] = 1'b1;
      tick();
      tick();
      bus.async_in[0] = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      total++;
      if ({bus.rise[1], bus.clean_out[0], bus.sync_out[0]} !== 3'b101) begin
         bad++;
         $display("FAIL arst_setup got=%b exp=101", {bus.rise[1], bus.clean_out[0], bus.sync_out[0]});
      end
      #2 n_rst = 1'b0;
      #1;
      total++;
      if ({bus.sync_out, bus.clean_out, bus.rise, bus.fall, bus.toggle_out} !== 20'h0) begin
         bad++;
         $display("FAIL arst_immediate got=%h exp=0",
                  {bus.sync_out, bus.clean_out, bus.rise, bus.fall, bus.toggle_out});
      end
      tick();
      tick();
      n_rst = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         total++;
         if ({bus.clean_out[0], bus.rise[0], bus.clean_out[1], bus.rise[1]} !==
             {(e >= 6), (e == 6), (e >= 6), (e == 6)}) begin
            bad++;
            $display("FAIL arst_restart e=%0d got=%b exp=%b", e,
                     {bus.clean_out[0], bus.rise[0], bus.clean_out[1], bus.rise[1]},
                     {(e >= 6), (e == 6), (e >= 6), (e == 6)});
         end
      end
   endtask

   // All inputs rise together; channel k is released after edge 6+2k and falls at edge 12+2k.
   task automatic test_independence();
      logic [3:0] exp_sync, exp_clean, exp_rise, exp_fall, exp_tog;
      int         h;
      apply_reset();
      bus.async_in = 4'hF;
      for (int e = 1; e <= 20; e++) begin
         tick();
         for (int k = 0; k < 4; k++) begin
            h            = 6 + 2 * k;
            if (e == h) bus.async_in[k] = 1'b0;
            exp_sync[k]  = (e >= 2 && e <= h + 1);
            exp_clean[k] = (e >= 6 && e < h + 6);
            exp_rise[k]  = (e == 6);
            exp_fall[k]  = (e == h + 6);
            exp_tog[k]   = (e >= 6);
         end
         total++;
         if ({bus.sync_out, bus.clean_out, bus.rise, bus.fall, bus.toggle_out} !==
             {exp_sync, exp_clean, exp_rise, exp_fall, exp_tog}) begin
            bad++;
            $display("FAIL indep e=%0d got=%h exp=%h", e,
                     {bus.sync_out, bus.clean_out, bus.rise, bus.fall, bus.toggle_out},
                     {exp_sync, exp_clean, exp_rise, exp_fall, exp_tog});
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_latency();
      test_glitch();
      test_toggle();
      test_clear_priority();
      test_async_reset();
      test_independence();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised multi-channel input front end for pushbutton and other asynchronous inputs.
Each channel passes through four stages in order: an N-stage synchronizer, a consecutive-cycle debouncer, rise/fall edge detection, and a JK-style toggle latch.
Sits between raw pb inputs and all downstream FSMs, replacing per-button flop/synchronizer instances.
All channels are independent and identical.

Parameters:
WIDTH, 21, number of independent channels
STAGES, 2, synchronizer flop depth per channel; legal range 2..4
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized level must differ from the clean level before it is accepted; legal range 1..255

Ports:
clk  input  1  system clock (100 Hz board clock or faster), rising-edge
n_rst  input  1  reset, asynchronous, active-low
async_in  input  WIDTH  raw asynchronous inputs
toggle_clr  input  WIDTH  synchronous per-channel clear of toggle_out
sync_out  output  WIDTH  synchronizer output (last stage)
clean_out  output  WIDTH  debounced level
rise  output  WIDTH  one-cycle pulse on clean_out 0->1
fall  output  WIDTH  one-cycle pulse on clean_out 1->0
toggle_out  output  WIDTH  flips on every rise; cleared by toggle_clr

Behaviour:
- Reset (n_rst low, asynchronous): every sync flop, debounce counter, clean_out, rise, fall and toggle_out go to 0 immediately. Held while n_rst is low.
- Synchronizer, per channel:
  - STAGES-deep shift chain; sync_out is the last stage.
  - A level sampled at edge k appears on sync_out after edge k+STAGES-1.
  - No logic between stages.
- Debouncer, per channel: counter cnt, width $clog2(DEBOUNCE_CYCLES+1). At each edge:
  - sync_out == clean_out: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: clean_out <= sync_out, cnt <= 0.
  - else: cnt <= cnt+1.
- Debounce latency:
  - clean_out changes exactly DEBOUNCE_CYCLES edges after sync_out first differs, provided sync_out holds the new level throughout.
  - Any return to the clean level before then resets cnt, and clean_out does not change (glitch rejection).
  - DEBOUNCE_CYCLES=1: clean_out follows sync_out with a one-cycle delay.
- Total latency: async_in stable before edge 1 gives sync_out valid after edge STAGES and clean_out after edge STAGES+DEBOUNCE_CYCLES.
- Edge detect, registered:
  - At the same edge clean_out goes 0->1, rise <= 1; otherwise rise <= 0.
  - fall is symmetric for 1->0.
  - rise and fall are each exactly one cycle wide, coincident with the first cycle of the new clean_out level.
  - rise and fall never assert together on one channel.
- Toggle latch, per channel, evaluated at the edge where clean_out goes 0->1. Priority:
  - toggle_clr = 1: toggle_out <= 0. Clear wins even if a rise occurs at the same edge.
  - else if clean_out rising: toggle_out <= ~toggle_out.
  - else: hold.
- Boundaries:
  - Input held high through reset release: treated as a normal 0->1 input. clean_out rises after STAGES+DEBOUNCE_CYCLES edges, rise pulses, toggle_out flips to 1.
  - Reset asserted mid-debounce: cnt is lost. After release, the count restarts from 0.
  - Reset asserted mid-pulse: rise and fall drop immediately.
  - Counter never exceeds DEBOUNCE_CYCLES-1. No wrap is possible.
  - Channels never interact. Simultaneous events on different channels are fully independent.

Test Plan:
Parameters for all tests: WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4.
1. Reset and latency: release n_rst with async_in=0. Set async_in[0]=1 before edge 1 -> sync_out[0]=1 after edge 2; clean_out[0]=1 after edge 6; rise[0]=1 for exactly the cycle after edge 6; toggle_out[0]=1.
2. Glitch rejection: with clean_out[1]=0, pulse async_in[1] high for 3 cycles -> sync_out[1] high for 3 cycles; clean_out, rise and toggle_out on channel 1 stay 0. A 4-cycle pulse -> clean_out[1] high for exactly 4 cycles, one rise, one fall.
3. Toggle sequence: three clean presses on channel 2 -> toggle_out[2] goes 1, 0, 1. fall[2] pulses once per release.
4. Clear priority: drive toggle_clr[3]=1 at the same edge clean_out[3] rises, with toggle_out[3]=1 beforehand -> toggle_out[3]=0 and rise[3]=1 in the same cycle.
5. Async reset mid-operation: assert n_rst low between edges while channel 0 is mid-count (cnt=2) and rise[1]=1 -> all outputs 0 immediately, before the next edge. After release with input still high, clean_out[0] rises 6 edges later.
6. Independence: switch all four inputs on the same cycle with staggered release times -> each channel's rise, fall and clean timing matches its single-channel result exactly.
